// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD sector arbiter.
//  - arb_state_t : arbiter FSM states
//  - LBA_W       : sector address width
//  - DIR_RD/WR   : transfer direction encoding latched at grant time
package sd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } arb_state_t;

    localparam int LBA_W = 32;

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin encoder.
// Ports:
//  pending [N]  request vector
//  ptr     [W]  search start index (must be < N)
//  valid        at least one pending bit set
//  idx     [W]  first pending index at or after ptr, wrapping to 0
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] pending,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] idx
);

    // Scan N positions starting at ptr; the first hit wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!valid && pending[(int'(ptr) + k) % N]) begin
                valid = 1'b1;
                idx   = W'((int'(ptr) + k) % N);
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/sd_sector_arbiter.sv
// Shares the single MCU-backed SD sector channel between NREQ requesters.
// Level requests are granted round-robin; the granted index, LBA and
// direction are forwarded to the SD side and sd_busy/sd_done are routed
// back to the granted requester only.
// Ports:
//  clk, reset            clock, asynchronous active-high reset
//  req_rd/req_wr [NREQ]  per-requester level requests
//  req_lba [NREQ*32]     per-requester LBA, requester i at [32*i +: 32]
//  req_busy [NREQ]       sd_busy routed to the granted requester
//  req_done/req_err      one-cycle completion / timeout-abort pulses
//  sd_rd, sd_wr          request to SD side
//  sd_idx, sd_lba        granted requester number and latched LBA
//  sd_busy, sd_done      SD side acceptance / completion
module sd_sector_arbiter
    import sd_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDXW    = 2,
    parameter int TIMEOUT = 1048576
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_rd,
    input  logic [NREQ-1:0]      req_wr,
    input  logic [NREQ*LBA_W-1:0] req_lba,
    output logic [NREQ-1:0]      req_busy,
    output logic [NREQ-1:0]      req_done,
    output logic [NREQ-1:0]      req_err,
    output logic                 sd_rd,
    output logic                 sd_wr,
    output logic [IDXW-1:0]      sd_idx,
    output logic [LBA_W-1:0]     sd_lba,
    input  logic                 sd_busy,
    input  logic                 sd_done
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t        state_r, state_s;
    logic [IDXW-1:0]   gnt_r, gnt_s;
    logic [IDXW-1:0]   rr_r, rr_s;
    logic [LBA_W-1:0]  lba_r, lba_s;
    logic              sd_rd_r, sd_rd_s;
    logic              sd_wr_r, sd_wr_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [NREQ-1:0]   done_r, done_s;
    logic [NREQ-1:0]   err_r, err_s;
    logic [NREQ-1:0]   pending_s;
    logic              pick_valid_s;
    logic [IDXW-1:0]   pick_idx_s;
    logic [IDXW-1:0]   next_ptr_s;
    logic              dir_s;

    assign pending_s = req_rd | req_wr;

    rr_pick #(
        .N (NREQ),
        .W (IDXW)
    ) u_rr_pick (
        .pending (pending_s),
        .ptr     (rr_r),
        .valid   (pick_valid_s),
        .idx     (pick_idx_s)
    );

    // Round-robin pointer moves just past the requester being released.
    always_comb begin
        if (gnt_r == IDXW'(NREQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = gnt_r + IDXW'(1);
        end
    end

    // Next-state and next-output logic for the arbiter FSM.
    always_comb begin
        state_s = state_r;
        gnt_s   = gnt_r;
        rr_s    = rr_r;
        lba_s   = lba_r;
        sd_rd_s = sd_rd_r;
        sd_wr_s = sd_wr_r;
        cnt_s   = cnt_r;
        done_s  = '0;
        err_s   = '0;
        dir_s   = DIR_RD;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    // Read wins when a requester raises both lines.
                    dir_s   = req_rd[pick_idx_s] ? DIR_RD : DIR_WR;
                    gnt_s   = pick_idx_s;
                    lba_s   = req_lba[LBA_W*int'(pick_idx_s) +: LBA_W];
                    sd_rd_s = (dir_s == DIR_RD);
                    sd_wr_s = (dir_s == DIR_WR);
                    // Loaded with TIMEOUT-1 so the request is held exactly TIMEOUT cycles.
                    cnt_s   = CNT_W'(TIMEOUT - 1);
                    state_s = REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (sd_busy) begin
                    sd_rd_s = 1'b0;
                    sd_wr_s = 1'b0;
                    // Busy and done together means a transfer already completed.
                    if (sd_done) begin
                        done_s[gnt_r] = 1'b1;
                        rr_s          = next_ptr_s;
                        state_s       = IDLE;
                    end else begin
                        state_s = XFER;
                    end
                end else if (cnt_r == CNT_W'(0)) begin
                    sd_rd_s       = 1'b0;
                    sd_wr_s       = 1'b0;
                    done_s[gnt_r] = 1'b1;
                    err_s[gnt_r]  = 1'b1;
                    rr_s          = next_ptr_s;
                    state_s       = IDLE;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            XFER: begin
                // The MCU owns transfer length, so no timeout here.
                if (sd_done) begin
                    done_s[gnt_r] = 1'b1;
                    rr_s          = next_ptr_s;
                    state_s       = IDLE;
                end else begin
                    state_s = XFER;
                end
            end
            default: begin
                sd_rd_s = 1'b0;
                sd_wr_s = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // FSM state, grant latches, timeout counter and response pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            gnt_r   <= '0;
            rr_r    <= '0;
            lba_r   <= '0;
            sd_rd_r <= 1'b0;
            sd_wr_r <= 1'b0;
            cnt_r   <= '0;
            done_r  <= '0;
            err_r   <= '0;
        end else begin
            state_r <= state_s;
            gnt_r   <= gnt_s;
            rr_r    <= rr_s;
            lba_r   <= lba_s;
            sd_rd_r <= sd_rd_s;
            sd_wr_r <= sd_wr_s;
            cnt_r   <= cnt_s;
            done_r  <= done_s;
            err_r   <= err_s;
        end
    end

    // sd_busy is passed straight through to the owner of the grant.
    always_comb begin
        req_busy = '0;
        if (state_r != IDLE) begin
            req_busy[gnt_r] = sd_busy;
        end else begin
            req_busy = '0;
        end
    end

    assign sd_rd    = sd_rd_r;
    assign sd_wr    = sd_wr_r;
    assign sd_idx   = gnt_r;
    assign sd_lba   = lba_r;
    assign req_done = done_r;
    assign req_err  = err_r;

endmodule

// File: tb/tb_sd_sector_arbiter.sv
module tb_sd_sector_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   req_rd;
    logic [3:0]   req_wr;
    logic [127:0] req_lba;
    logic [3:0]   req_busy;
    logic [3:0]   req_done;
    logic [3:0]   req_err;
    logic         sd_rd;
    logic         sd_wr;
    logic [1:0]   sd_idx;
    logic [31:0]  sd_lba;
    logic         sd_busy;
    logic         sd_done;

    int tests;
    int fails;

    sd_sector_arbiter #(
        .NREQ    (4),
        .IDXW    (2),
        .TIMEOUT (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_rd   (req_rd),
        .req_wr   (req_wr),
        .req_lba  (req_lba),
        .req_busy (req_busy),
        .req_done (req_done),
        .req_err  (req_err),
        .sd_rd    (sd_rd),
        .sd_wr    (sd_wr),
        .sd_idx   (sd_idx),
        .sd_lba   (sd_lba),
        .sd_busy  (sd_busy),
        .sd_done  (sd_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rd;
        logic [3:0]  wr;
        logic        busy;
        logic        done;
        logic [3:0]  exp_busy;
        logic        exp_rd;
        logic        exp_wr;
        logic [1:0]  exp_idx;
        logic [31:0] exp_lba;
        logic [3:0]  exp_done;
        logic [3:0]  exp_err;
    } vec_t;

    vec_t vecs[23];

    localparam logic [31:0] L0 = 32'hAAAA0000;
    localparam logic [31:0] L1 = 32'h00001234;
    localparam logic [31:0] L2 = 32'hCCCC2222;
    localparam logic [31:0] L3 = 32'hDDDD3333;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        sd_busy = 1'b1;
        sd_done = 1'b0;
        tick();
        tick();
        #1;
        chk("rst_sd_rd", 32'(sd_rd), 32'd0);
        chk("rst_sd_wr", 32'(sd_wr), 32'd0);
        chk("rst_sd_idx", 32'(sd_idx), 32'd0);
        chk("rst_sd_lba", sd_lba, 32'd0);
        chk("rst_req_busy", 32'(req_busy), 32'd0);
        chk("rst_req_done", 32'(req_done), 32'd0);
        chk("rst_req_err", 32'(req_err), 32'd0);
        sd_busy = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Wait for a grant, check it, then run a normal busy/done handshake.
    task automatic serve(input int idx, input logic exp_wr);
        int n;
        n = 0;
        while (!(sd_rd || sd_wr) && n < 20) begin
            tick();
            n++;
        end
        chk("grant_wait", 32'(n < 20), 32'd1);
        chk("grant_idx", 32'(sd_idx), 32'(idx));
        chk("grant_wr", 32'(sd_wr), 32'(exp_wr));
        chk("grant_rd", 32'(sd_rd), 32'(!exp_wr));
        sd_busy = 1'b1;
        #1;
        chk("busy_route", 32'(req_busy), 32'(1 << idx));
        req_rd[idx] = 1'b0;
        req_wr[idx] = 1'b0;
        tick();
        sd_busy = 1'b0;
        sd_done = 1'b1;
        tick();
        sd_done = 1'b0;
        chk("done_route", 32'(req_done), 32'(1 << idx));
        chk("done_err", 32'(req_err), 32'd0);
    endtask

    initial begin
        int n;
        tests   = 0;
        fails   = 0;
        reset   = 1'b1;
        req_rd  = '0;
        req_wr  = '0;
        sd_busy = 1'b0;
        sd_done = 1'b0;
        req_lba = {L3, L2, L1, L0};

        //            rd       wr       bsy   dn    ebusy    erd   ewr   eidx  elba  edone    eerr
        vecs[0]  = '{4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd1, L1, 4'b0000, 4'b0000};
        vecs[1]  = '{4'b0010, 4'b0000, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0, 2'd1, L1, 4'b0000, 4'b0000};
        vecs[2]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0, 2'd1, L1, 4'b0000, 4'b0000};
        vecs[3]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd1, L1, 4'b0010, 4'b0000};
        vecs[4]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd1, L1, 4'b0000, 4'b0000};
        vecs[5]  = '{4'b0100, 4'b0100, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd2, L2, 4'b0000, 4'b0000};
        vecs[6]  = '{4'b0100, 4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0, 2'd2, L2, 4'b0000, 4'b0000};
        vecs[7]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd2, L2, 4'b0100, 4'b0000};
        vecs[8]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd2, L2, 4'b0000, 4'b0000};
        vecs[9]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd2, L2, 4'b0000, 4'b0000};
        vecs[10] = '{4'b1000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd3, L3, 4'b0000, 4'b0000};
        vecs[11] = '{4'b1000, 4'b0000, 1'b1, 1'b1, 4'b1000, 1'b0, 1'b0, 2'd3, L3, 4'b1000, 4'b0000};
        vecs[12] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd3, L3, 4'b0000, 4'b0000};
        vecs[13] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd3, L3, 4'b0000, 4'b0000};
        vecs[14] = '{4'b0000, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, L0, 4'b0000, 4'b0000};
        vecs[15] = '{4'b0000, 4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, L0, 4'b0000, 4'b0000};
        vecs[16] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, L0, 4'b0001, 4'b0000};
        vecs[17] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, L0, 4'b0000, 4'b0000};
        vecs[18] = '{4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd1, L1, 4'b0000, 4'b0000};
        vecs[19] = '{4'b0010, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd1, L1, 4'b0000, 4'b0000};
        vecs[20] = '{4'b0010, 4'b0000, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0, 2'd1, L1, 4'b0000, 4'b0000};
        vecs[21] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd1, L1, 4'b0010, 4'b0000};
        vecs[22] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd1, L1, 4'b0000, 4'b0000};

        // Single read, rd+wr priority, stray done, busy+done together, write, done in REQ.
        do_reset();
        for (int i = 0; i < 23; i++) begin
            req_rd  = vecs[i].rd;
            req_wr  = vecs[i].wr;
            sd_busy = vecs[i].busy;
            sd_done = vecs[i].done;
            #1;
            chk($sformatf("v%0d_req_busy", i), 32'(req_busy), 32'(vecs[i].exp_busy));
            tick();
            chk($sformatf("v%0d_sd_rd", i), 32'(sd_rd), 32'(vecs[i].exp_rd));
            chk($sformatf("v%0d_sd_wr", i), 32'(sd_wr), 32'(vecs[i].exp_wr));
            chk($sformatf("v%0d_sd_idx", i), 32'(sd_idx), 32'(vecs[i].exp_idx));
            chk($sformatf("v%0d_sd_lba", i), sd_lba, vecs[i].exp_lba);
            chk($sformatf("v%0d_req_done", i), 32'(req_done), 32'(vecs[i].exp_done));
            chk($sformatf("v%0d_req_err", i), 32'(req_err), 32'(vecs[i].exp_err));
        end
        req_rd  = '0;
        req_wr  = '0;
        sd_busy = 1'b0;
        sd_done = 1'b0;

        // Contention held from reset: 0, 2 (write), 3, then re-asserted 0.
        reset  = 1'b1;
        req_rd = 4'b1001;
        req_wr = 4'b0100;
        do_reset();
        serve(0, 1'b0);
        req_rd[0] = 1'b1;
        serve(2, 1'b1);
        serve(3, 1'b0);
        serve(0, 1'b0);

        // Timeout: requester 1 never sees sd_busy, requester 2 goes next.
        req_rd = 4'b0000;
        req_wr = 4'b0000;
        do_reset();
        req_rd = 4'b0110;
        tick();
        chk("to_grant_idx", 32'(sd_idx), 32'd1);
        n = 0;
        while (sd_rd && n < 100) begin
            n++;
            tick();
        end
        chk("to_sd_rd_cycles", 32'(n), 32'd16);
        chk("to_req_done", 32'(req_done), 32'b0010);
        chk("to_req_err", 32'(req_err), 32'b0010);
        req_rd[1] = 1'b0;
        tick();
        chk("to_next_rd", 32'(sd_rd), 32'd1);
        chk("to_next_idx", 32'(sd_idx), 32'd2);
        chk("to_next_done", 32'(req_done), 32'd0);
        chk("to_next_err", 32'(req_err), 32'd0);
        serve(2, 1'b0);

        // Async reset mid-transfer, then re-arbitration from index 0.
        do_reset();
        req_rd = 4'b0010;
        serve(1, 1'b0);
        req_rd = 4'b0101;
        tick();
        chk("ar_grant_idx", 32'(sd_idx), 32'd2);
        sd_busy = 1'b1;
        tick();
        #1;
        chk("ar_xfer_busy", 32'(req_busy), 32'b0100);
        reset = 1'b1;
        #1;
        chk("ar_sd_rd", 32'(sd_rd), 32'd0);
        chk("ar_sd_wr", 32'(sd_wr), 32'd0);
        chk("ar_req_busy", 32'(req_busy), 32'd0);
        chk("ar_sd_idx", 32'(sd_idx), 32'd0);
        sd_busy = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("ar_regrant_rd", 32'(sd_rd), 32'd1);
        chk("ar_regrant_idx", 32'(sd_idx), 32'd0);
        chk("ar_regrant_lba", sd_lba, L0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
